// File: rtl/multi_channel_delay_line.sv
// ============================================================================
// Module      : multi_channel_delay_line
// Description : CH-lane shift delay line with run-time depth (0..MAX_DEPTH)
//               and valid/ready handshake on both sides. Optional drain of
//               the stored samples is compiled in with DELAY_LINE_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_channel_delay_line #(
  parameter int WIDTH     = 8,
  parameter int CH        = 1,
  parameter int MAX_DEPTH = 32,
  parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [DEPTH_W-1:0]    depth,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [CH*WIDTH-1:0]   din,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [CH*WIDTH-1:0]   dout,
  output logic [DEPTH_W-1:0]    fill
`ifdef DELAY_LINE_FLUSH_EN
  ,
  input  logic                  flush,
  output logic                  out_last
`endif
);

  localparam logic [DEPTH_W-1:0] c_max_depth = DEPTH_W'(MAX_DEPTH);

`ifdef DELAY_LINE_FLUSH_EN
  typedef enum logic [1:0] {S_FILL = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_FILL = 2'd0, S_RUN = 2'd1} state_t;
`endif

  state_t                r_state, w_state_nxt;
  logic [DEPTH_W-1:0]    r_fill, w_fill_nxt;
  logic [DEPTH_W-1:0]    r_depth_q;
  logic                  r_out_vld, w_vld_nxt;
  logic [CH*WIDTH-1:0]   r_dout, w_dout_nxt;
  logic [CH*WIDTH-1:0]   r_sr [MAX_DEPTH];

  logic [DEPTH_W-1:0]    w_depth_clamp, w_depth_eff;
  logic                  w_depth_ld, w_space, w_pop, w_accept;
  logic                  w_in_flush, w_flushing, w_inject, w_shift;
  logic                  w_filling, w_load;
  logic [CH*WIDTH-1:0]   w_shift_data, w_tap;

`ifdef DELAY_LINE_FLUSH_EN
  logic                  r_out_last, w_last_nxt;
  logic [DEPTH_W-1:0]    r_flush_cnt, w_cnt_nxt;
  assign w_in_flush = (r_state == S_FLUSH);
  assign out_last   = r_out_last;
`else
  assign w_in_flush = 1'b0;
`endif

  // Depth is only re-sampled while the line is empty, so the live value is
  // used in the very cycle it loads.
  assign w_depth_clamp = (depth > c_max_depth) ? c_max_depth : depth;
  assign w_depth_ld    = clr | ((r_fill == '0) & !r_out_vld);
  assign w_depth_eff   = w_depth_ld ? w_depth_clamp : r_depth_q;

  assign w_space      = !r_out_vld | out_rdy;
  assign w_pop        = r_out_vld & out_rdy;
  assign in_rdy       = rst & !clr & !w_in_flush & w_space;
  assign w_accept     = in_vld & in_rdy;
  assign w_flushing   = w_in_flush & !clr;
  assign w_inject     = w_flushing & w_space;
  assign w_shift      = w_accept | w_inject;
  assign w_shift_data = w_flushing ? '0 : din;
  assign w_filling    = (r_fill < w_depth_eff);
  assign w_load       = w_shift & !w_filling;

  assign out_vld = r_out_vld;
  assign dout    = r_dout;
  assign fill    = r_fill;

  // Zero depth taps the incoming sample directly.
  always_comb begin
    w_tap = w_shift_data;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (w_depth_eff == DEPTH_W'(k + 1)) w_tap = r_sr[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < MAX_DEPTH; k++) r_sr[k] <= '0;
    end else if (w_shift) begin
      r_sr[0] <= w_shift_data;
      for (int k = 1; k < MAX_DEPTH; k++) r_sr[k] <= r_sr[k-1];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_vld_nxt   = r_out_vld;
    w_dout_nxt  = r_dout;
`ifdef DELAY_LINE_FLUSH_EN
    w_last_nxt  = r_out_last;
    w_cnt_nxt   = r_flush_cnt;
`endif
    if (w_load) begin
      w_vld_nxt  = 1'b1;
      w_dout_nxt = w_tap;
`ifdef DELAY_LINE_FLUSH_EN
      w_last_nxt = 1'b0;
`endif
    end else if (w_pop) begin
      w_vld_nxt  = 1'b0;
`ifdef DELAY_LINE_FLUSH_EN
      w_last_nxt = 1'b0;
`endif
    end
    if (w_shift && w_filling) w_fill_nxt = r_fill + DEPTH_W'(1);

    case (r_state)
`ifdef DELAY_LINE_FLUSH_EN
      S_FLUSH: begin
        if (w_load) begin
          w_cnt_nxt = r_flush_cnt - DEPTH_W'(1);
          if (r_flush_cnt == DEPTH_W'(1)) begin
            w_last_nxt  = 1'b1;
            w_fill_nxt  = '0;
            w_state_nxt = (r_depth_q == '0) ? S_RUN : S_FILL;
          end
        end
      end
`endif
      default: begin
        w_state_nxt = (w_fill_nxt == w_depth_eff) ? S_RUN : S_FILL;
`ifdef DELAY_LINE_FLUSH_EN
        if (flush && (r_fill != '0)) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = w_fill_nxt;
        end
`endif
      end
    endcase

    if (clr) begin
      w_fill_nxt  = '0;
      w_vld_nxt   = 1'b0;
      w_state_nxt = (w_depth_clamp == '0) ? S_RUN : S_FILL;
`ifdef DELAY_LINE_FLUSH_EN
      w_last_nxt  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_FILL;
      r_fill      <= '0;
      r_depth_q   <= '0;
      r_out_vld   <= 1'b0;
      r_dout      <= '0;
`ifdef DELAY_LINE_FLUSH_EN
      r_out_last  <= 1'b0;
      r_flush_cnt <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_fill      <= w_fill_nxt;
      r_depth_q   <= w_depth_eff;
      r_out_vld   <= w_vld_nxt;
      r_dout      <= w_dout_nxt;
`ifdef DELAY_LINE_FLUSH_EN
      r_out_last  <= w_last_nxt;
      r_flush_cnt <= w_cnt_nxt;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_delay_line.sv
// Testbench for multi_channel_delay_line (CH=2, MAX_DEPTH=32); scoreboard-based.
`default_nettype none

module tb_multi_channel_delay_line;
  localparam int WIDTH     = 8;
  localparam int CH        = 2;
  localparam int MAX_DEPTH = 32;
  localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst, clr, in_vld, in_rdy, out_vld, out_rdy;
  logic [DEPTH_W-1:0]  depth, fill;
  logic [CH*WIDTH-1:0] din, dout;
`ifdef DELAY_LINE_FLUSH_EN
  logic                flush, out_last;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pop = 0;
  logic [15:0] last_pop = '0;
  int          m_depth = 0;
  logic [15:0] m_hist[$];
  logic [15:0] m_exp[$];
  logic [16:0] m_seen[$];
  bit          m_en = 1'b1;
  logic        m_exp_vld;
  logic        m_rdy_exp;
  logic [15:0] m_e;

  always #5 clk = ~clk;

  multi_channel_delay_line #(
    .WIDTH(WIDTH), .CH(CH), .MAX_DEPTH(MAX_DEPTH), .DEPTH_W(DEPTH_W)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .depth(depth),
    .in_vld(in_vld), .in_rdy(in_rdy), .din(din),
    .out_vld(out_vld), .out_rdy(out_rdy), .dout(dout), .fill(fill)
`ifdef DELAY_LINE_FLUSH_EN
    , .flush(flush), .out_last(out_last)
`endif
  );

  function automatic logic [15:0] pack(input int n);
    logic [7:0] a;
    logic [7:0] b;
    a = n[7:0];
    b = 8'(n + 100);
    return {b, a};
  endfunction

  function automatic int clampd(input logic [DEPTH_W-1:0] d);
    return (int'(d) > MAX_DEPTH) ? MAX_DEPTH : int'(d);
  endfunction

  // Reference delay line: m_hist holds stored samples, m_exp the output register.
  always @(negedge clk) begin
    if (!rst) begin
      m_hist.delete();
      m_exp.delete();
    end else begin
      if (out_vld && out_rdy)
`ifdef DELAY_LINE_FLUSH_EN
        m_seen.push_back({out_last, dout});
`else
        m_seen.push_back({1'b0, dout});
`endif
      if (m_en) begin
        m_exp_vld = (m_exp.size() != 0);
        if (m_hist.size() == 0 && !m_exp_vld) m_depth = clampd(depth);
        n_cmp++;
        if (out_vld !== m_exp_vld) begin
          n_err++;
          $display("FAIL out_vld: got %b want %b at %0t", out_vld, m_exp_vld, $time);
        end
        m_rdy_exp = !clr && (!m_exp_vld || out_rdy);
        n_cmp++;
        if (in_rdy !== m_rdy_exp) begin
          n_err++;
          $display("FAIL in_rdy: got %b want %b at %0t", in_rdy, m_rdy_exp, $time);
        end
        n_cmp++;
        if (int'(fill) !== m_hist.size()) begin
          n_err++;
          $display("FAIL fill: got %0d want %0d at %0t", fill, m_hist.size(), $time);
        end
        if (out_vld && out_rdy) begin
          n_pop++;
          last_pop = dout;
          if (m_exp.size() != 0) begin
            m_e = m_exp.pop_front();
            n_cmp++;
            if (dout !== m_e) begin
              n_err++;
              $display("FAIL dout: got %h want %h at %0t", dout, m_e, $time);
            end
          end
        end
        if (clr) begin
          m_hist.delete();
          m_exp.delete();
        end else if (in_vld && in_rdy) begin
          m_hist.push_back(din);
          if (m_hist.size() > m_depth) m_exp.push_back(m_hist.pop_front());
        end
      end
    end
  end

  task automatic feed(input int first, input int last, input logic [3:0] pat, output bit to);
    int cur;
    int cyc;
    cur = first;
    cyc = 0;
    to  = 1'b0;
    while (cur <= last) begin
      @(posedge clk); #1;
      in_vld  = 1'b1;
      din     = pack(cur);
      out_rdy = pat[2'(cyc)];
      @(negedge clk);
      if (in_rdy) cur++;
      cyc++;
      if (cyc > 2000) begin
        to = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_vld  = 1'b0;
      out_rdy = 1'b1;
    end
  endtask

  task automatic do_clr();
    @(posedge clk); #1;
    clr    = 1'b1;
    in_vld = 1'b0;
    @(posedge clk); #1;
    clr    = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL reset in_rdy: got %b want 0", in_rdy); end
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL reset out_vld: got %b want 0", out_vld); end
    n_cmp++; if (dout !== '0) begin n_err++; $display("FAIL reset dout: got %h want 0", dout); end
    n_cmp++; if (fill !== '0) begin n_err++; $display("FAIL reset fill: got %0d want 0", fill); end
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic test_fill_run();
    int p0;
    bit to;
    p0 = n_pop;
    feed(1, 8, 4'b1111, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL fill_run timeout: got 1 want 0"); end
    drain(5);
    n_cmp++; if (n_pop - p0 !== 5) begin n_err++; $display("FAIL fill_run count: got %0d want 5", n_pop - p0); end
    n_cmp++; if (last_pop !== pack(5)) begin n_err++; $display("FAIL fill_run last: got %h want %h", last_pop, pack(5)); end
  endtask

  task automatic test_pass_through();
    int p0;
    bit to;
    depth = '0;
    do_clr();
    p0 = n_pop;
    feed(7, 7, 4'b1111, to);
    n_cmp++; if (out_vld !== 1'b1 || dout !== pack(7)) begin
      n_err++; $display("FAIL pass latency: got vld=%b dout=%h want vld=1 dout=%h", out_vld, dout, pack(7));
    end
    feed(9, 9, 4'b1111, to);
    drain(3);
    n_cmp++; if (n_pop - p0 !== 2 || last_pop !== pack(9)) begin
      n_err++; $display("FAIL pass count: got %0d/%h want 2/%h", n_pop - p0, last_pop, pack(9));
    end
  endtask

  task automatic test_back_pressure();
    int p0;
    bit to;
    depth = DEPTH_W'(2);
    do_clr();
    p0 = n_pop;
    feed(1, 10, 4'b1001, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL bp timeout: got 1 want 0"); end
    drain(4);
    n_cmp++; if (n_pop - p0 !== 8 || last_pop !== pack(8)) begin
      n_err++; $display("FAIL bp count: got %0d/%h want 8/%h", n_pop - p0, last_pop, pack(8));
    end
  endtask

  task automatic test_clamp_lock();
    int p0;
    bit to;
    depth = DEPTH_W'(40);
    do_clr();
    p0 = n_pop;
    feed(1, 40, 4'b1111, to);
    depth = DEPTH_W'(5);
    feed(41, 60, 4'b1111, to);
    drain(3);
    n_cmp++; if (n_pop - p0 !== 28 || last_pop !== pack(28)) begin
      n_err++; $display("FAIL clamp count: got %0d/%h want 28/%h", n_pop - p0, last_pop, pack(28));
    end
    do_clr();
    n_cmp++; if (fill !== '0 || out_vld !== 1'b0) begin
      n_err++; $display("FAIL clamp clr: got fill=%0d vld=%b want 0/0", fill, out_vld);
    end
    p0 = n_pop;
    feed(61, 70, 4'b1111, to);
    drain(3);
    n_cmp++; if (n_pop - p0 !== 5 || last_pop !== pack(65)) begin
      n_err++; $display("FAIL relock count: got %0d/%h want 5/%h", n_pop - p0, last_pop, pack(65));
    end
  endtask

  task automatic test_reset_clear();
    int p0;
    bit to;
    depth = DEPTH_W'(3);
    do_clr();
    feed(1, 5, 4'b1111, to);
    n_cmp++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL pre-reset vld: got %b want 1", out_vld); end
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (out_vld !== 1'b0 || dout !== '0 || fill !== '0 || in_rdy !== 1'b0) begin
      n_err++; $display("FAIL async reset: got vld=%b dout=%h fill=%0d rdy=%b want 0/0/0/0", out_vld, dout, fill, in_rdy);
    end
    @(posedge clk); #2 rst = 1'b1;
    feed(1, 4, 4'b1111, to);
    @(posedge clk); #1;
    clr    = 1'b1;
    in_vld = 1'b1;
    din    = pack(99);
    @(posedge clk); #1;
    clr    = 1'b0;
    in_vld = 1'b0;
    n_cmp++; if (fill !== '0 || out_vld !== 1'b0) begin
      n_err++; $display("FAIL clr+accept: got fill=%0d vld=%b want 0/0", fill, out_vld);
    end
    p0 = n_pop;
    feed(11, 14, 4'b1111, to);
    drain(4);
    n_cmp++; if (n_pop - p0 !== 1 || last_pop !== pack(11)) begin
      n_err++; $display("FAIL clr drop: got %0d/%h want 1/%h", n_pop - p0, last_pop, pack(11));
    end
  endtask

`ifdef DELAY_LINE_FLUSH_EN
  task automatic test_flush();
    bit to;
    bit done;
    logic [16:0] want;
    depth = DEPTH_W'(4);
    do_clr();
    m_seen.delete();
    feed(1, 6, 4'b1111, to);
    m_en  = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    done  = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (fill == '0 && !out_vld) done = 1'b1;
    end
    n_cmp++; if (!done) begin n_err++; $display("FAIL flush timeout: got 0 want 1"); end
    n_cmp++; if (m_seen.size() !== 6) begin n_err++; $display("FAIL flush count: got %0d want 6", m_seen.size()); end
    for (int i = 0; i < 6 && i < m_seen.size(); i++) begin
      want = {(i == 5), pack(i + 1)};
      n_cmp++;
      if (m_seen[i] !== want) begin
        n_err++; $display("FAIL flush item %0d: got %h want %h", i, m_seen[i], want);
      end
    end
    feed(21, 21, 4'b1111, to);
    @(posedge clk); #1;
    n_cmp++; if (fill !== DEPTH_W'(1) || out_vld !== 1'b0) begin
      n_err++; $display("FAIL post-flush fill: got fill=%0d vld=%b want 1/0", fill, out_vld);
    end
  endtask
`endif

  initial begin
    rst     = 1'b1;
    clr     = 1'b0;
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    din     = '0;
    depth   = DEPTH_W'(3);
`ifdef DELAY_LINE_FLUSH_EN
    flush   = 1'b0;
`endif
    test_reset();
    test_fill_run();
    test_pass_through();
    test_back_pressure();
    test_clamp_lock();
    test_reset_clear();
`ifdef DELAY_LINE_FLUSH_EN
    test_flush();
`endif
    drain(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
